// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage for the single-cycle core. Owns the program counter, drives the
// word address into a synchronous-read instruction RAM (1-cycle latency) and
// presents each returned word to decode with its PC and a valid flag.
// Handles decode back-pressure, execute redirects and stops itself on HALT.
//
// Optional feature: define FETCH_BOUND_CHECK_EN to trap fetches whose PC lies
// outside the implemented RAM (upper PC bits non-zero). Without it the fault
// output is tied low and the RAM simply aliases on the low IMEM_AW bits.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned         PC_W     = 32,
  parameter int unsigned         IMEM_AW  = 7,
  parameter logic [PC_W-1:0]     RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_stall,
  input  logic            i_redirect_valid,
  input  logic [PC_W-1:0] i_redirect_pc,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic [31:0]     i_imem_rdata,
  output logic [31:0]     o_instr,
  output logic [PC_W-1:0] o_instr_pc,
  output logic            o_instr_valid,
  output logic            o_halted,
  output logic            o_fault
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]      HALT_OPC  = 4'b1001;

  state_t          r_state;
  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_pend_pc;
  logic            r_pend_valid;

  logic            w_instr_valid;
  logic            w_halt_seen;
  logic            w_issue;
  logic            w_bound_trip;
  logic            w_fault_set;

  // The word in flight is meaningful only while running; HALTED/IDLE hide it.
  assign w_instr_valid = r_pend_valid & (r_state == ST_RUN);

  // HALT is recognised only on a delivered (valid) word.
  assign w_halt_seen   = w_instr_valid & (i_imem_rdata[31:28] == HALT_OPC);

  // Step-4 condition: nothing of higher priority claims this edge.
  assign w_issue       = (r_state == ST_RUN) & ~i_redirect_valid & ~i_stall & ~w_halt_seen;

`ifdef FETCH_BOUND_CHECK_EN
  // Any set bit above the implemented RAM address range is an illegal fetch.
  assign w_bound_trip  = |(r_fetch_pc >> IMEM_AW);
`else
  assign w_bound_trip  = 1'b0;
`endif

  assign w_fault_set   = w_issue & w_bound_trip;

  // Under stall the pending address is replayed so the RAM re-reads the held word.
  assign o_imem_addr   = i_stall ? r_pend_pc : r_fetch_pc;

  assign o_instr       = i_imem_rdata;
  assign o_instr_pc    = r_pend_pc;
  assign o_instr_valid = w_instr_valid;
  assign o_halted      = (r_state == ST_HALTED);

  // Fetch state machine: PC advance, redirect squash, stall hold, HALT/fault stop.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_pend_pc    <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state      <= ST_RUN;
            r_fetch_pc   <= RESET_PC;
            r_pend_valid <= 1'b0;
          end else begin
            r_state      <= ST_IDLE;
          end
        end

        ST_RUN: begin
          if (i_redirect_valid) begin
            // Wrong-path word (even a HALT) is discarded; target fetched next.
            r_fetch_pc   <= i_redirect_pc;
            r_pend_valid <= 1'b0;
          end else if (i_stall) begin
            // Hold everything; the replayed address keeps imem_rdata stable.
            r_state      <= ST_RUN;
          end else if (w_halt_seen) begin
            r_state      <= ST_HALTED;
            r_pend_valid <= 1'b0;
          end else if (w_fault_set) begin
            r_state      <= ST_HALTED;
            r_pend_valid <= 1'b0;
          end else begin
            r_pend_pc    <= r_fetch_pc;
            r_pend_valid <= 1'b1;
            r_fetch_pc   <= r_fetch_pc + PC_ONE;
          end
        end

        ST_HALTED: begin
          // Terminal until reset.
          r_state      <= ST_HALTED;
          r_pend_valid <= 1'b0;
        end

        default: begin
          r_state      <= ST_IDLE;
          r_fetch_pc   <= RESET_PC;
          r_pend_pc    <= '0;
          r_pend_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_BOUND_CHECK_EN
  logic r_fault;

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fault <= 1'b0;
    end else if (w_fault_set) begin
      r_fault <= 1'b1;
    end else begin
      r_fault <= r_fault;
    end
  end

  assign o_fault = r_fault;
`else
  assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit with a behavioural 128-word synchronous
// RAM. Expected values are hand-derived from the program table below.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int PC_W = 32;
  localparam logic [31:0] HALT_W = 32'h9000_0000;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            stall;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr;
  logic [PC_W-1:0] instr_pc;
  logic            instr_valid;
  logic            halted;
  logic            fault;

  logic [31:0] mem [0:127];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Synchronous-read instruction RAM, 1-cycle latency, aliases on low 7 bits.
  always @(posedge clk) imem_rdata <= mem[imem_addr[6:0]];

  instr_fetch_unit #(.PC_W(32), .IMEM_AW(7), .RESET_PC(32'd0)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_start          (start),
    .i_stall          (stall),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_imem_addr      (imem_addr),
    .i_imem_rdata     (imem_rdata),
    .o_instr          (instr),
    .o_instr_pc       (instr_pc),
    .o_instr_valid    (instr_valid),
    .o_halted         (halted),
    .o_fault          (fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_deliv(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check_eq({tag, "_pc"},    instr_pc, pc);
    check_eq({tag, "_instr"}, instr, mem[pc[6:0]]);
  endtask

  task automatic check_idle_outs(input string tag);
    check_eq({tag, "_valid"},  {31'd0, instr_valid}, 32'd0);
    check_eq({tag, "_halted"}, {31'd0, halted},      32'd0);
    check_eq({tag, "_fault"},  {31'd0, fault},       32'd0);
    check_eq({tag, "_pc"},     instr_pc,             32'd0);
    check_eq({tag, "_addr"},   imem_addr,            32'd0);
  endtask

  task automatic check_halted(input string tag, input logic exp_fault);
    check_eq({tag, "_halted"}, {31'd0, halted},      32'd1);
    check_eq({tag, "_valid"},  {31'd0, instr_valid}, 32'd0);
    check_eq({tag, "_fault"},  {31'd0, fault},       {31'd0, exp_fault});
  endtask

  // Pulse start; returns in the second cycle after the sampling edge.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  // Guard against any unforeseen hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 | i;
    mem[0] = 32'h1010_0000;
    mem[7] = HALT_W;

    // Reset state
    #12;
    check_idle_outs("rst");
    tick();
    tick();
    check_idle_outs("rst_hold");
    reset = 1'b0;
    tick();
    check_idle_outs("idle");

    // Start: address issued in cycle after E0, data valid in the second
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_addr",  imem_addr, 32'd0);
    check_eq("start_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check_deliv("start", 32'd0);
    check_eq("start_word", instr, 32'h1010_0000);

    // Sequential delivery with a 3-cycle stall at pc 3
    for (int pc = 1; pc <= 3; pc++) begin
      tick();
      check_deliv("seq", pc);
    end
    stall = 1'b1;
    #1;
    check_eq("stall_addr", imem_addr, 32'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_deliv("stall_hold", 32'd3);
    end
    stall = 1'b0;
    for (int pc = 4; pc <= 7; pc++) begin
      tick();
      check_deliv("seq2", pc);
    end
    check_eq("halt_word", instr, HALT_W);
    tick();
    check_halted("halt", 1'b0);
    tick();
    check_halted("halt_stay", 1'b0);

    // Redirect from pc 6 back to 2: one bubble
    pulse_reset();
    do_start();
    check_deliv("rs", 32'd0);
    for (int pc = 1; pc <= 6; pc++) begin
      tick();
      check_deliv("rd_pre", pc);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'd2;
    tick();
    redirect_valid = 1'b0;
    check_eq("rd_bubble", {31'd0, instr_valid}, 32'd0);
    check_eq("rd_addr",   imem_addr, 32'd2);
    tick();
    check_deliv("rd_tgt", 32'd2);
    tick();
    check_deliv("rd_next", 32'd3);

    // Redirect coincident with stall: redirect wins
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'd5;
    tick();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    check_eq("rs_bubble", {31'd0, instr_valid}, 32'd0);
    tick();
    check_deliv("rs_tgt", 32'd5);
    tick();
    check_deliv("rs_next", 32'd6);
    tick();
    check_deliv("rh_halt", 32'd7);

    // Redirect coincident with HALT word: no halt
    redirect_valid = 1'b1;
    redirect_pc    = 32'd1;
    tick();
    redirect_valid = 1'b0;
    check_eq("rh_nohalt", {31'd0, halted}, 32'd0);
    check_eq("rh_bubble", {31'd0, instr_valid}, 32'd0);
    for (int pc = 1; pc <= 5; pc++) begin
      tick();
      check_deliv("rh_run", pc);
    end

    // Async reset between edges at pc 5
    #2;
    reset = 1'b1;
    #1;
    check_idle_outs("async");
    #1;
    reset = 1'b0;
    do_start();
    check_deliv("restart", 32'd0);

    // Boundary: RAM without HALT, run past pc 127
    pulse_reset();
    mem[7] = 32'h1000_0007;
    do_start();
    check_deliv("bnd", 32'd0);
    for (int pc = 1; pc <= 127; pc++) begin
      tick();
      check_deliv("bnd", pc);
    end
    tick();
`ifdef FETCH_BOUND_CHECK_EN
    check_halted("bnd_fault", 1'b1);
    tick();
    check_halted("bnd_fault_stay", 1'b1);
`else
    check_deliv("bnd_alias", 32'd128);
    check_eq("bnd_alias_word", instr, 32'h1010_0000);
    check_eq("bnd_nofault", {31'd0, fault}, 32'd0);
    tick();
    check_deliv("bnd_alias2", 32'd129);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
